// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/funct values, datapath mux selects and decoded instruction classes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_RS      = 2'd1;
  localparam logic [1:0] PC_TARGET  = 2'd2;
  localparam logic [1:0] PC_LATCHED = 2'd3;

  localparam logic [1:0] REG_RT  = 2'd0;
  localparam logic [1:0] REG_RD  = 2'd1;
  localparam logic [1:0] REG_R31 = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  typedef enum logic [3:0] {
    CL_NOP, CL_RALU, CL_ADDIU, CL_LW, CL_SW,
    CL_JR, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_HALT
  } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class,
// plus a flag that is low for any opcode or R-type funct the core does not support.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    iclass = CL_NOP;
    legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_SLT, FN_SLTU: iclass = CL_RALU;
          FN_JR:                   iclass = CL_JR;
          default:                 legal  = 1'b0;
        endcase
      end
      OP_ADDIU: iclass = CL_ADDIU;
      OP_LW:    iclass = CL_LW;
      OP_SW:    iclass = CL_SW;
      OP_BEQ:   iclass = CL_BEQ;
      OP_BNE:   iclass = CL_BNE;
      OP_J:     iclass = CL_J;
      OP_JAL:   iclass = CL_JAL;
      OP_HALT:  iclass = CL_HALT;
      default:  legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with wait-request stalls,
// optional memory timeout and delay slot. Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes.
module mips_multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT          = 16,
  parameter bit          BRANCH_DELAY_SLOT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] instr_opcode,
  input  logic [5:0] instr_funct,
  input  logic       mem_waitrequest,
  input  logic       alu_zero,
  output logic [2:0] state,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       target_latch,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [5:0] alu_op,
  output logic       halt,
  output logic       active,
  output logic       timeout_err,
  output logic       illegal_err
);

  localparam logic [31:0] WAIT_LAST = (MAX_WAIT == 0) ? 32'd0 : MAX_WAIT - 32'd1;

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic        slot_q, slot_d;
  logic        timeout_q, timeout_d;
  logic [31:0] wait_q, wait_d;
  iclass_t     iclass;
  logic        legal;
  logic        redirect;
  logic        stall_expired;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal_q, illegal_d;
`endif

  ctrl_decode u_decode (
    .opcode (instr_opcode),
    .funct  (instr_funct),
    .iclass (iclass),
    .legal  (legal)
  );

  assign stall_expired = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);

  // pending: a redirect target is latched; slot: its delay-slot instruction is in flight
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    slot_d       = slot_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d    = illegal_q;
`endif
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    target_latch = 1'b0;
    reg_dst      = REG_RT;
    mem_to_reg   = WB_ALU;
    alu_src      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    redirect     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_waitrequest) begin
          wait_d = wait_q + 32'd1;
          if (stall_expired) begin
            timeout_d = 1'b1;
            pending_d = 1'b0;
            slot_d    = 1'b0;
            state_d   = S_HALTED;
          end
        end else begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          wait_d   = 32'd0;
          if (pending_q && slot_q) begin
            pc_src    = PC_LATCHED;
            pending_d = 1'b0;
            slot_d    = 1'b0;
          end else if (pending_q) begin
            slot_d = 1'b1;
          end
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (iclass == CL_HALT) begin
          pending_d = 1'b0;
          slot_d    = 1'b0;
          state_d   = S_HALTED;
        end else if (legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          pending_d = 1'b0;
          slot_d    = 1'b0;
          state_d   = S_HALTED;
`else
          state_d   = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (iclass)
          CL_RALU: begin
            reg_dst = REG_RD;
            state_d = S_WB;
          end
          CL_ADDIU: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          CL_LW, CL_SW: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          CL_JR: begin
            redirect = 1'b1;
            pc_src   = PC_RS;
          end
          CL_BEQ: begin
            redirect = alu_zero;
            pc_src   = alu_zero ? PC_TARGET : PC_PLUS4;
          end
          CL_BNE: begin
            redirect = ~alu_zero;
            pc_src   = alu_zero ? PC_PLUS4 : PC_TARGET;
          end
          CL_J: begin
            redirect = 1'b1;
            pc_src   = PC_TARGET;
          end
          CL_JAL: begin
            redirect = 1'b1;
            pc_src   = PC_TARGET;
            state_d  = slot_q ? S_FETCH : S_WB;
          end
          default: state_d = S_FETCH;
        endcase
        // A redirect issued from inside a delay slot is dropped; the first target wins
        if (redirect) begin
          if (slot_q) begin
            pc_src = PC_PLUS4;
          end else if (BRANCH_DELAY_SLOT) begin
            target_latch = 1'b1;
            pending_d    = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
      end
      S_MEM: begin
        if (iclass == CL_SW) mem_write = 1'b1;
        else                 mem_read  = 1'b1;
        if (mem_waitrequest) begin
          wait_d = wait_q + 32'd1;
          if (stall_expired) begin
            timeout_d = 1'b1;
            pending_d = 1'b0;
            slot_d    = 1'b0;
            state_d   = S_HALTED;
          end
        end else begin
          wait_d  = 32'd0;
          state_d = (iclass == CL_SW) ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        case (iclass)
          CL_RALU: reg_dst = REG_RD;
          CL_LW:   mem_to_reg = WB_MEM;
          CL_JAL: begin
            reg_dst    = REG_R31;
            mem_to_reg = WB_LINK;
          end
          default: begin
            reg_dst    = REG_RT;
            mem_to_reg = WB_ALU;
          end
        endcase
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase

    if (reset) begin
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
      mem_write    = 1'b0;
      target_latch = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pending_q <= 1'b0;
      slot_q    <= 1'b0;
      wait_q    <= 32'd0;
      timeout_q <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      slot_q    <= slot_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign state       = state_q;
  assign alu_op      = instr_opcode;
  assign halt        = (state_q == S_HALTED);
  assign active      = (state_q != S_HALTED);
  assign timeout_err = timeout_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_err = illegal_q;
`else
  assign illegal_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: instance a has a delay slot and MAX_WAIT=4,
// instance b has no delay slot and no timeout; both share the same stimulus.
module tb_mips_multicycle_control;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset, mem_waitrequest, alu_zero;
  logic [5:0] instr_opcode, instr_funct;

  logic [2:0] state_a, state_b;
  logic ir_write_a, pc_write_a, target_latch_a, alu_src_a, mem_read_a, mem_write_a, reg_write_a;
  logic ir_write_b, pc_write_b, target_latch_b, alu_src_b, mem_read_b, mem_write_b, reg_write_b;
  logic [1:0] pc_src_a, reg_dst_a, mem_to_reg_a, pc_src_b, reg_dst_b, mem_to_reg_b;
  logic [5:0] alu_op_a, alu_op_b;
  logic halt_a, active_a, timeout_err_a, illegal_err_a;
  logic halt_b, active_b, timeout_err_b, illegal_err_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.MAX_WAIT(4), .BRANCH_DELAY_SLOT(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_opcode(instr_opcode), .instr_funct(instr_funct),
    .mem_waitrequest(mem_waitrequest), .alu_zero(alu_zero), .state(state_a),
    .ir_write(ir_write_a), .pc_write(pc_write_a), .pc_src(pc_src_a),
    .target_latch(target_latch_a), .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a),
    .alu_src(alu_src_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
    .reg_write(reg_write_a), .alu_op(alu_op_a), .halt(halt_a), .active(active_a),
    .timeout_err(timeout_err_a), .illegal_err(illegal_err_a)
  );

  mips_multicycle_control #(.MAX_WAIT(0), .BRANCH_DELAY_SLOT(1'b0)) dut_nd (
    .clk(clk), .reset(reset), .instr_opcode(instr_opcode), .instr_funct(instr_funct),
    .mem_waitrequest(mem_waitrequest), .alu_zero(alu_zero), .state(state_b),
    .ir_write(ir_write_b), .pc_write(pc_write_b), .pc_src(pc_src_b),
    .target_latch(target_latch_b), .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b),
    .alu_src(alu_src_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .reg_write(reg_write_b), .alu_op(alu_op_b), .halt(halt_b), .active(active_b),
    .timeout_err(timeout_err_b), .illegal_err(illegal_err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_waitrequest = 1'b0; alu_zero = 1'b0;
    instr_opcode = 6'b000000; instr_funct = 6'b000000;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_waitrequest = 1'b0; instr_opcode = 6'b000000; instr_funct = 6'b100001;
    tick(); tick(); #1;
    total++; if (state_a !== S_FETCH) $display("FAIL rst_state: got %0d want %0d", state_a, S_FETCH); else passed++;
    total++; if (ir_write_a !== 1'b0) $display("FAIL rst_ir_write_forced: got %0b want 0", ir_write_a); else passed++;
    total++; if (pc_write_a !== 1'b0) $display("FAIL rst_pc_write_forced: got %0b want 0", pc_write_a); else passed++;
    total++; if ({halt_a, active_a} !== 2'b01) $display("FAIL rst_halt_active: got %b want 01", {halt_a, active_a}); else passed++;
    total++; if ({timeout_err_a, illegal_err_a} !== 2'b00) $display("FAIL rst_errs: got %b want 00", {timeout_err_a, illegal_err_a}); else passed++;
    reset = 1'b0; #1;
    total++; if ({ir_write_a, pc_write_a, mem_read_a} !== 3'b111) $display("FAIL rst_release_fetch: got %b want 111", {ir_write_a, pc_write_a, mem_read_a}); else passed++;
  endtask

  task automatic test_addu();
    int wr_cycles = 0;
    do_reset();
    instr_opcode = 6'b000000; instr_funct = 6'b100001; #1;
    total++; if ({ir_write_a, pc_write_a, pc_src_a} !== 4'b1100) $display("FAIL addu_fetch: got %b want 1100", {ir_write_a, pc_write_a, pc_src_a}); else passed++;
    total++; if (alu_op_a !== 6'b000000) $display("FAIL addu_alu_op: got %0h want 0", alu_op_a); else passed++;
    wr_cycles += reg_write_a;
    tick(); #1;
    total++; if (state_a !== S_DECODE) $display("FAIL addu_c2_state: got %0d want %0d", state_a, S_DECODE); else passed++;
    wr_cycles += reg_write_a;
    tick(); #1;
    total++; if ({state_a, reg_dst_a} !== {S_EXEC, 2'd1}) $display("FAIL addu_c3_exec: got %b want %b", {state_a, reg_dst_a}, {S_EXEC, 2'd1}); else passed++;
    wr_cycles += reg_write_a;
    tick(); #1;
    total++; if ({state_a, reg_write_a, reg_dst_a, mem_to_reg_a} !== {S_WB, 1'b1, 2'd1, 2'd0}) $display("FAIL addu_c4_wb: got %b want %b", {state_a, reg_write_a, reg_dst_a, mem_to_reg_a}, {S_WB, 1'b1, 2'd1, 2'd0}); else passed++;
    wr_cycles += reg_write_a;
    tick(); #1;
    total++; if (state_a !== S_FETCH) $display("FAIL addu_c5_state: got %0d want %0d", state_a, S_FETCH); else passed++;
    wr_cycles += reg_write_a;
    total++; if (wr_cycles !== 1) $display("FAIL addu_reg_write_cycles: got %0d want 1", wr_cycles); else passed++;
  endtask

  task automatic test_lw_stall();
    do_reset();
    instr_opcode = 6'b100011; #1;
    tick(); #1;
    tick(); #1;
    total++; if ({state_a, alu_src_a} !== {S_EXEC, 1'b1}) $display("FAIL lw_exec: got %b want %b", {state_a, alu_src_a}, {S_EXEC, 1'b1}); else passed++;
    tick(); mem_waitrequest = 1'b1; #1;
    for (int c = 0; c < 3; c++) begin
      total++; if ({state_a, mem_read_a, reg_write_a} !== {S_MEM, 1'b1, 1'b0}) $display("FAIL lw_mem_stall%0d: got %b want %b", c, {state_a, mem_read_a, reg_write_a}, {S_MEM, 1'b1, 1'b0}); else passed++;
      tick();
    end
    mem_waitrequest = 1'b0; #1;
    total++; if ({state_a, mem_read_a} !== {S_MEM, 1'b1}) $display("FAIL lw_mem_done: got %b want %b", {state_a, mem_read_a}, {S_MEM, 1'b1}); else passed++;
    tick(); #1;
    total++; if ({state_a, reg_write_a, reg_dst_a, mem_to_reg_a} !== {S_WB, 1'b1, 2'd0, 2'd1}) $display("FAIL lw_wb: got %b want %b", {state_a, reg_write_a, reg_dst_a, mem_to_reg_a}, {S_WB, 1'b1, 2'd0, 2'd1}); else passed++;
    total++; if (timeout_err_a !== 1'b0) $display("FAIL lw_no_timeout: got %0b want 0", timeout_err_a); else passed++;
    tick(); #1;
    total++; if (state_a !== S_FETCH) $display("FAIL lw_cycle9_fetch: got %0d want %0d", state_a, S_FETCH); else passed++;
  endtask

  task automatic test_sw();
    do_reset();
    instr_opcode = 6'b101011; #1;
    tick(); tick(); tick(); #1;
    total++; if ({state_a, mem_write_a, mem_read_a} !== {S_MEM, 1'b1, 1'b0}) $display("FAIL sw_mem: got %b want %b", {state_a, mem_write_a, mem_read_a}, {S_MEM, 1'b1, 1'b0}); else passed++;
    tick(); #1;
    total++; if ({state_a, reg_write_a} !== {S_FETCH, 1'b0}) $display("FAIL sw_back_to_fetch: got %b want %b", {state_a, reg_write_a}, {S_FETCH, 1'b0}); else passed++;
  endtask

  task automatic test_beq_delay_slot();
    do_reset();
    instr_opcode = 6'b000100; alu_zero = 1'b1; #1;
    tick(); tick(); #1;
    total++; if ({target_latch_a, pc_write_a, pc_src_a} !== 4'b1010) $display("FAIL beq_a_exec: got %b want 1010", {target_latch_a, pc_write_a, pc_src_a}); else passed++;
    total++; if ({target_latch_b, pc_write_b, pc_src_b} !== 4'b0110) $display("FAIL beq_b_exec: got %b want 0110", {target_latch_b, pc_write_b, pc_src_b}); else passed++;
    tick(); instr_opcode = 6'b001001; alu_zero = 1'b0; #1;
    total++; if ({state_a, pc_write_a, pc_src_a} !== {S_FETCH, 1'b1, 2'd0}) $display("FAIL beq_slot_fetch: got %b want %b", {state_a, pc_write_a, pc_src_a}, {S_FETCH, 1'b1, 2'd0}); else passed++;
    tick(); tick(); #1;
    total++; if ({state_a, alu_src_a, target_latch_a} !== {S_EXEC, 1'b1, 1'b0}) $display("FAIL beq_addiu_exec: got %b want %b", {state_a, alu_src_a, target_latch_a}, {S_EXEC, 1'b1, 1'b0}); else passed++;
    tick(); #1;
    total++; if ({reg_write_a, reg_dst_a, mem_to_reg_a} !== 5'b10000) $display("FAIL beq_addiu_wb: got %b want 10000", {reg_write_a, reg_dst_a, mem_to_reg_a}); else passed++;
    tick(); instr_opcode = 6'b000000; instr_funct = 6'b100001; #1;
    total++; if ({state_a, pc_write_a, pc_src_a} !== {S_FETCH, 1'b1, 2'd3}) $display("FAIL beq_target_fetch_a: got %b want %b", {state_a, pc_write_a, pc_src_a}, {S_FETCH, 1'b1, 2'd3}); else passed++;
    total++; if (pc_src_b !== 2'd0) $display("FAIL beq_target_fetch_b: got %0d want 0", pc_src_b); else passed++;
    tick(); tick(); tick(); tick(); #1;
    total++; if ({state_a, pc_src_a} !== {S_FETCH, 2'd0}) $display("FAIL beq_pending_cleared: got %b want %b", {state_a, pc_src_a}, {S_FETCH, 2'd0}); else passed++;
  endtask

  task automatic test_bne();
    do_reset();
    instr_opcode = 6'b000101; alu_zero = 1'b1; #1;
    tick(); tick(); #1;
    total++; if ({target_latch_a, pc_write_b, pc_src_b} !== 4'b0000) $display("FAIL bne_not_taken: got %b want 0000", {target_latch_a, pc_write_b, pc_src_b}); else passed++;
    tick(); alu_zero = 1'b0; #1;
    total++; if ({state_a, pc_src_a} !== {S_FETCH, 2'd0}) $display("FAIL bne_latency3: got %b want %b", {state_a, pc_src_a}, {S_FETCH, 2'd0}); else passed++;
    tick(); tick(); #1;
    total++; if ({target_latch_a, pc_write_b, pc_src_b} !== 4'b1110) $display("FAIL bne_taken: got %b want 1110", {target_latch_a, pc_write_b, pc_src_b}); else passed++;
  endtask

  task automatic test_jal();
    do_reset();
    instr_opcode = 6'b000011; #1;
    tick(); tick(); #1;
    total++; if ({pc_write_b, pc_src_b, target_latch_b} !== 4'b1100) $display("FAIL jal_b_exec: got %b want 1100", {pc_write_b, pc_src_b, target_latch_b}); else passed++;
    total++; if ({pc_write_a, target_latch_a} !== 2'b01) $display("FAIL jal_a_exec: got %b want 01", {pc_write_a, target_latch_a}); else passed++;
    tick(); #1;
    total++; if ({state_b, reg_write_b, reg_dst_b, mem_to_reg_b} !== {S_WB, 1'b1, 2'd2, 2'd2}) $display("FAIL jal_b_wb: got %b want %b", {state_b, reg_write_b, reg_dst_b, mem_to_reg_b}, {S_WB, 1'b1, 2'd2, 2'd2}); else passed++;
    total++; if ({state_a, reg_write_a, reg_dst_a, mem_to_reg_a} !== {S_WB, 1'b1, 2'd2, 2'd2}) $display("FAIL jal_a_wb: got %b want %b", {state_a, reg_write_a, reg_dst_a, mem_to_reg_a}, {S_WB, 1'b1, 2'd2, 2'd2}); else passed++;
  endtask

  task automatic test_branch_in_slot();
    do_reset();
    instr_opcode = 6'b000000; instr_funct = 6'b001000; #1;
    tick(); tick(); #1;
    total++; if ({pc_write_b, pc_src_b} !== 3'b101) $display("FAIL jr_b_exec: got %b want 101", {pc_write_b, pc_src_b}); else passed++;
    total++; if ({target_latch_a, pc_write_a, pc_src_a} !== 4'b1001) $display("FAIL jr_a_exec: got %b want 1001", {target_latch_a, pc_write_a, pc_src_a}); else passed++;
    tick(); instr_opcode = 6'b000011; instr_funct = 6'b000000; #1;
    tick(); tick(); #1;
    total++; if ({target_latch_a, pc_write_a} !== 2'b00) $display("FAIL slot_jal_suppressed: got %b want 00", {target_latch_a, pc_write_a}); else passed++;
    tick(); #1;
    total++; if ({state_a, pc_write_a, pc_src_a} !== {S_FETCH, 1'b1, 2'd3}) $display("FAIL slot_jal_no_wb: got %b want %b", {state_a, pc_write_a, pc_src_a}, {S_FETCH, 1'b1, 2'd3}); else passed++;
    total++; if (state_b !== S_WB) $display("FAIL slot_jal_b_wb: got %0d want %0d", state_b, S_WB); else passed++;
  endtask

  task automatic test_halt_in_slot();
    do_reset();
    instr_opcode = 6'b000010; #1;
    tick(); tick(); tick(); instr_opcode = 6'b111111; #1;
    tick(); tick(); #1;
    total++; if ({state_a, halt_a, active_a} !== {S_HALTED, 1'b1, 1'b0}) $display("FAIL halt_slot_a: got %b want %b", {state_a, halt_a, active_a}, {S_HALTED, 1'b1, 1'b0}); else passed++;
    instr_opcode = 6'b000000; instr_funct = 6'b100001;
    tick(); tick(); tick(); #1;
    total++; if ({state_a, ir_write_a, pc_write_a, mem_read_a} !== {S_HALTED, 3'b000}) $display("FAIL halt_sticky: got %b want %b", {state_a, ir_write_a, pc_write_a, mem_read_a}, {S_HALTED, 3'b000}); else passed++;
    total++; if (state_b !== S_HALTED) $display("FAIL halt_b: got %0d want %0d", state_b, S_HALTED); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    mem_waitrequest = 1'b1; #1;
    for (int c = 1; c <= 4; c++) begin
      total++; if ({state_a, ir_write_a, mem_read_a, timeout_err_a} !== {S_FETCH, 1'b0, 1'b1, 1'b0}) $display("FAIL tmo_stall%0d: got %b want %b", c, {state_a, ir_write_a, mem_read_a, timeout_err_a}, {S_FETCH, 1'b0, 1'b1, 1'b0}); else passed++;
      tick();
    end
    total++; if ({state_a, timeout_err_a, halt_a, active_a} !== {S_HALTED, 3'b110}) $display("FAIL tmo_halted: got %b want %b", {state_a, timeout_err_a, halt_a, active_a}, {S_HALTED, 3'b110}); else passed++;
    repeat (20) tick();
    total++; if ({state_b, timeout_err_b} !== {S_FETCH, 1'b0}) $display("FAIL tmo_disabled_b: got %b want %b", {state_b, timeout_err_b}, {S_FETCH, 1'b0}); else passed++;
    mem_waitrequest = 1'b0;
    tick(); #1;
    total++; if ({state_a, state_b} !== {S_HALTED, S_DECODE}) $display("FAIL tmo_after_release: got %b want %b", {state_a, state_b}, {S_HALTED, S_DECODE}); else passed++;
    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    total++; if ({state_a, timeout_err_a, halt_a} !== {S_FETCH, 2'b00}) $display("FAIL tmo_reset_clears: got %b want %b", {state_a, timeout_err_a, halt_a}, {S_FETCH, 2'b00}); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_opcode = 6'b000010; #1;
    tick(); tick(); tick(); instr_opcode = 6'b000000; instr_funct = 6'b100001; #1;
    tick(); tick(); tick(); reset = 1'b1; #1;
    total++; if ({state_a, reg_write_a} !== {S_WB, 1'b0}) $display("FAIL midrst_wb_forced: got %b want %b", {state_a, reg_write_a}, {S_WB, 1'b0}); else passed++;
    tick(); reset = 1'b0; #1;
    total++; if ({state_a, pc_write_a, pc_src_a} !== {S_FETCH, 1'b1, 2'd0}) $display("FAIL midrst_pending_cleared: got %b want %b", {state_a, pc_write_a, pc_src_a}, {S_FETCH, 1'b1, 2'd0}); else passed++;
  endtask

  task automatic test_illegal();
    logic [2:0] exp_state;
    logic       exp_err;
`ifdef CTRL_ILLEGAL_TRAP_EN
    exp_state = S_HALTED; exp_err = 1'b1;
`else
    exp_state = S_FETCH;  exp_err = 1'b0;
`endif
    do_reset();
    instr_opcode = 6'b010101; #1;
    tick(); #1;
    total++; if (state_a !== S_DECODE) $display("FAIL ill_op_decode: got %0d want %0d", state_a, S_DECODE); else passed++;
    tick(); #1;
    total++; if ({state_a, illegal_err_a} !== {exp_state, exp_err}) $display("FAIL ill_op_result: got %b want %b", {state_a, illegal_err_a}, {exp_state, exp_err}); else passed++;
    do_reset();
    instr_opcode = 6'b000000; instr_funct = 6'b000000; #1;
    tick(); tick(); #1;
    total++; if ({state_b, illegal_err_b} !== {exp_state, exp_err}) $display("FAIL ill_funct_result: got %b want %b", {state_b, illegal_err_b}, {exp_state, exp_err}); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_waitrequest = 1'b0; alu_zero = 1'b0;
    instr_opcode = 6'b000000; instr_funct = 6'b000000;
    test_reset();
    test_addu();
    test_lw_stall();
    test_sw();
    test_beq_delay_slot();
    test_bne();
    test_jal();
    test_branch_in_slot();
    test_halt_in_slot();
    test_timeout();
    test_reset_mid();
    test_illegal();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle control unit for the Harvard MIPS core; successor to the two-phase fetch/execute decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and stalls on memory wait-request.
- Adds an optional memory-timeout, optional branch delay slot, and branch/jump/link support.
- Sits between the instruction register and the datapath; drives all datapath enables and mux selects.

Parameters:
- MAX_WAIT, 16: max consecutive wait-request cycles tolerated per memory access; 0 = no timeout.
- BRANCH_DELAY_SLOT, 1: 1 = taken branch/jump redirects the PC after the next instruction completes; 0 = redirects immediately.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- instr_opcode  in  6  IR[31:26].
- instr_funct  in  6  IR[5:0].
- mem_waitrequest  in  1  active memory access not yet complete.
- alu_zero  in  1  ALU result == 0, valid in EXEC.
- state  out  3  current FSM state, for debug.
- ir_write  out  1  latch instruction.
- pc_write  out  1  update PC.
- pc_src  out  2  PC source: 0 = PC+4, 1 = rs, 2 = computed branch/jump target, 3 = latched target.
- target_latch  out  1  datapath stores the computed target.
- reg_dst  out  2  destination register: 0 = rt, 1 = rd, 2 = r31.
- mem_to_reg  out  2  write-back source: 0 = ALU, 1 = memory, 2 = link (PC+8).
- alu_src  out  1  ALU operand 2 is the immediate.
- mem_read  out  1  memory read.
- mem_write  out  1  memory write.
- reg_write  out  1  register-file write.
- alu_op  out  6  opcode passthrough.
- halt  out  1  core halted.
- active  out  1  not halted.
- timeout_err  out  1  sticky; a memory access exceeded MAX_WAIT.
- illegal_err  out  1  sticky; illegal opcode trap.

Behaviour:
- State register:
  - States: FETCH, DECODE, EXEC, MEM, WB, HALTED.
  - On reset: state = FETCH; pending = 0; wait counter = 0; timeout_err, illegal_err, halt = 0.
  - While reset is high, ir_write, pc_write, reg_write, mem_write and target_latch are forced to 0.
- Outputs: combinational from state, opcode and funct. Any output not listed for a state is 0.
- FETCH:
  - mem_read = 1.
  - While mem_waitrequest = 1: hold state, no strobes.
  - On the cycle mem_waitrequest = 0: ir_write = 1, pc_write = 1, pc_src = 3 if pending else 0; clear pending; go to DECODE.
- DECODE (1 cycle):
  - Opcode 6'b111111: go to HALTED.
  - Supported opcode: go to EXEC.
  - Other opcode: go to FETCH (treated as NOP; see Optional Feature).
- EXEC (1 cycle), by instruction class:
  - R-ALU (funct ADDU/SUBU/AND/OR/XOR/SLT/SLTU): reg_dst = 1; go to WB.
  - ADDIU: alu_src = 1; go to WB.
  - LW, SW: alu_src = 1; go to MEM.
  - JR (funct 6'b001000): redirect with pc_src = 1; go to FETCH.
  - BEQ / BNE: taken when alu_zero = 1 (BEQ) or alu_zero = 0 (BNE). Taken: redirect with pc_src = 2. Go to FETCH.
  - J: redirect with pc_src = 2; go to FETCH.
  - JAL: redirect with pc_src = 2; go to WB.
- Redirect rule:
  - BRANCH_DELAY_SLOT = 0: pc_write = 1 in EXEC.
  - BRANCH_DELAY_SLOT = 1: target_latch = 1 and pending is set; no pc_write in EXEC.
- MEM:
  - LW: mem_read = 1; SW: mem_write = 1. Both hold while mem_waitrequest = 1.
  - On completion: LW goes to WB; SW goes to FETCH.
- WB (1 cycle): reg_write = 1, then FETCH.
  - R-ALU: reg_dst = 1, mem_to_reg = 0.
  - ADDIU: reg_dst = 0, mem_to_reg = 0.
  - LW: reg_dst = 0, mem_to_reg = 1.
  - JAL: reg_dst = 2, mem_to_reg = 2.
- HALTED: halt = 1, active = 0, all strobes 0; exits only on reset.
- Timeout:
  - The wait counter increments each stalled cycle in FETCH or MEM and clears when an access completes.
  - When MAX_WAIT ≠ 0 and the counter reaches MAX_WAIT while still stalled: set timeout_err, go to HALTED.
- Boundary cases:
  - Branch or jump in a delay slot: its redirect is suppressed (no pc_write, no target_latch, no JAL write-back); pending keeps the first target.
  - HALT in a delay slot: HALTED takes effect and pending is discarded.
  - Reset mid-stall or mid-instruction: FSM returns to FETCH; pending, counters and sticky errors clear.
- Latency without stalls: R-ALU/ADDIU 4, LW 5, SW 4, J/JR/branch 3, JAL 4 cycles.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode or R-type funct in DECODE goes to HALTED and sets illegal_err.
- Undefined: it is a NOP (DECODE goes to FETCH) and illegal_err is tied to 0. The port is always present.

Decomposition:
- Package ctrl_pkg:
  - state enum.
  - opcode and funct localparams, including HALT = 6'b111111.
  - pc_src, reg_dst and mem_to_reg encodings.
  - instruction-class enum.
- Sub-module ctrl_decode: combinational opcode/funct → instruction class and legal flag. The FSM instantiates it once.

Test Plan:
- ADDU with 0 wait states: states FETCH→DECODE→EXEC→WB; reg_write = 1 on cycle 4 only, with reg_dst = 1.
- LW with mem_waitrequest high for 3 cycles in MEM: stays in MEM 4 cycles; then WB with mem_to_reg = 1; total 8 cycles.
- BEQ taken (alu_zero = 1) with BRANCH_DELAY_SLOT = 1, followed by ADDIU: target_latch in EXEC; ADDIU completes; next FETCH has pc_write = 1 and pc_src = 3.
- JAL with BRANCH_DELAY_SLOT = 0: pc_write with pc_src = 2 in EXEC; WB with reg_dst = 2 and mem_to_reg = 2.
- MAX_WAIT = 4, waitrequest held in FETCH: HALTED on the 4th stalled cycle; timeout_err = 1, halt = 1; reset returns to FETCH with both cleared.
- Opcode 6'b010101: with CTRL_ILLEGAL_TRAP_EN → HALTED and illegal_err = 1; without it → FETCH after DECODE and illegal_err = 0.
